// File: rtl/mau_pkg.sv
// Shared encodings and memory geometry for the load/store unit.
// Pure definitions: no latency, no flow control.
package mau_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } mau_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } mau_state_e;

    localparam int DM_WORDS = 3072;
    localparam int DM_BYTES = 12288;

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LW, OP_SW:          bad = (lo != 2'b00);
            OP_LH, OP_LHU, OP_SH:  bad = lo[0];
            default:               bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mau_lane.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
// Purely combinational; no flow control.
module mau_lane
    import mau_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [4:0]  w_shamt;
    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_bmask;

    assign w_shamt   = {i_addr_lo, 3'b000};
    assign w_shifted = i_rdata >> w_shamt;
    assign w_byte    = w_shifted[7:0];
    assign w_half    = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    assign w_bmask   = 32'h0000_00FF << w_shamt;

    always_comb begin
        o_load = 32'h0;
        case (i_op)
            OP_LW:   o_load = i_rdata;
            OP_LH:   o_load = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_load = {16'h0, w_half};
            OP_LB:   o_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_load = {24'h0, w_byte};
            default: o_load = 32'h0;
        endcase
    end

    always_comb begin
        o_merged = i_rdata;
        case (i_op)
            OP_SH:   o_merged = i_addr_lo[1] ? {i_wdata[15:0], i_rdata[15:0]}
                                             : {i_rdata[31:16], i_wdata[15:0]};
            OP_SB:   o_merged = (i_rdata & ~w_bmask) | ({24'h0, i_wdata[7:0]} << w_shamt);
            default: o_merged = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store unit over a 3072-word data memory; 2-cycle response (3 for SH/SB read-modify-write).
// Accepts one request at a time in IDLE; response held until resp_ready.
module mem_access_unit
    import mau_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [2:0]  i_req_op,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [31:0] i_req_pc,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_exc,
    output logic [11:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_mem_pc
);

    mau_state_e  r_state;
    mau_op_e     r_op;
    logic [1:0]  r_addr_lo;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_exc;
    logic [11:0] r_mem_addr;
    logic        r_mem_we;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_mem_pc;

    logic        w_err;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_err = is_misaligned(i_req_op, i_req_addr[1:0]) || (i_req_addr >= 32'(DM_BYTES));

    // r_mem_wdata carries the latched store data until the merge overwrites it
    mau_lane u_lane (
        .i_op      (r_op),
        .i_addr_lo (r_addr_lo),
        .i_rdata   (i_mem_rdata),
        .i_wdata   (r_mem_wdata),
        .o_load    (w_load),
        .o_merged  (w_merged)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_LW;
            r_addr_lo    <= 2'b00;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_exc   <= 1'b0;
            r_mem_addr   <= 12'h0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= 32'h0;
            r_mem_pc     <= 32'h0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_op         <= mau_op_e'(i_req_op);
                        r_addr_lo    <= i_req_addr[1:0];
                        r_mem_pc     <= i_req_pc;
                        r_resp_exc   <= w_err;
                        r_resp_rdata <= 32'h0;
                        r_req_ready  <= 1'b0;
                        r_state      <= ST_ACCESS;
                        if (!w_err) begin
                            r_mem_addr  <= i_req_addr[13:2];
                            r_mem_wdata <= i_req_wdata;
                            r_mem_we    <= (i_req_op == OP_SW);
                        end
                    end
                end
                // Faulted requests idle through this slot so every 2-cycle response lines up
                ST_ACCESS: begin
                    if (r_resp_exc) begin
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end else if (r_op == OP_SH || r_op == OP_SB) begin
                        r_mem_wdata <= w_merged;
                        r_mem_we    <= 1'b1;
                        r_state     <= ST_WRITE;
                    end else begin
                        if (r_op != OP_SW) r_resp_rdata <= w_load;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_exc   = r_resp_exc;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_we     = r_mem_we;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_mem_pc     = r_mem_pc;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and asynchronous, active-low reset: clk input 1 rising-edge clock; reset input 1 asynchronous active-low reset.
REQ-002 The block SHALL have these CPU-side ports:
- req_valid input 1: access request.
- req_ready output 1: unit can accept a request.
- req_op input 3: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
- req_addr input 32: byte address.
- req_wdata input 32: store data; low-order bits are used for SH/SB.
- req_pc input 32: PC of the issuing instruction, latched for the trace.
REQ-003 The block SHALL have these response ports:
- resp_valid output 1: response held.
- resp_ready input 1: CPU accepts the response.
- resp_rdata output 32: extended load data; 0 for stores.
- resp_exc output 1: misaligned or out-of-range access.
REQ-004 The block SHALL have these data-memory-side ports:
- mem_addr output 12: word index.
- mem_we output 1: word write enable.
- mem_wdata output 32: word write data.
- mem_rdata input 32: combinational read of mem_addr.
- mem_pc output 32: latched PC for the store trace.

Function
REQ-005 The FSM SHALL have the states IDLE, ACCESS, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-006 In IDLE, req_valid SHALL latch op, addr, wdata and pc.
- Misaligned or out-of-range requests SHALL go to RESP with resp_exc=1 and make no memory access.
- All other requests SHALL go to ACCESS.
REQ-007 Misalignment SHALL be defined as: word ops with addr[1:0]!=0; half ops with addr[0]!=0; byte ops never. Out of range SHALL mean addr >= 12288.
REQ-008 ACCESS SHALL drive mem_addr=addr[13:2]. The action by op is:
- Loads: select the byte or half by addr[1:0], sign- or zero-extend per op, register it into resp_rdata, then go to RESP.
- SW: assert mem_we with mem_wdata=wdata for exactly this cycle, then go to RESP.
- SH and SB: register the merge of mem_rdata with wdata[15:0] or wdata[7:0] at the addressed lane, then go to WRITE.
REQ-009 WRITE SHALL assert mem_we for one cycle with the merged word at the same mem_addr, then go to RESP.
REQ-010 RESP SHALL hold resp_valid=1 and resp_rdata/resp_exc stable until resp_ready=1. On that cycle the FSM SHALL return to IDLE, and no new request is accepted in the same cycle.
REQ-011 Request-to-response latency SHALL be: LW/LH/LHU/LB/LBU/SW/error 2 cycles; SH/SB 3 cycles; each case counted from the accepting edge to resp_valid rising.
REQ-012 mem_we SHALL be 0 in IDLE, RESP and on every error path; exactly one write occurs per store.
REQ-013 Lane mapping SHALL be little-endian: byte k occupies bits [8k+7:8k]; half at addr[1]=1 occupies [31:16].
REQ-014 req_* inputs SHALL be ignored outside IDLE.

Reset
REQ-015 When reset=0, regardless of clk, the FSM SHALL enter IDLE and every output SHALL be driven as follows:
- req_ready=1.
- resp_valid=0, resp_rdata=0, resp_exc=0.
- mem_we=0, mem_addr=0, mem_wdata=0, mem_pc=0.
REQ-016 Reset asserted during WRITE SHALL suppress the pending write; a partially merged store SHALL be discarded.

Structure
REQ-017 A package mau_pkg SHALL hold:
- the op encoding enum;
- the FSM state enum;
- DM_WORDS=3072;
- DM_BYTES=12288.
REQ-018 Lane extraction/extension and lane merging SHALL live in one combinational sub-module, mau_lane. The FSM and registers SHALL stay in mem_access_unit.

Verification
REQ-019 The bench SHALL cover these directed scenarios, each as stimulus -> required response:
- SW addr=0x10 wdata=0xDEADBEEF -> mem_we 1 cycle, mem_addr=4, mem_wdata=0xDEADBEEF. Then LW 0x10 -> resp_rdata=0xDEADBEEF after 2 cycles.
- Word 4 = 0x11223344. SB addr=0x12 wdata=0xAA -> one read, one write of 0x11AA3344, 3-cycle latency. Then LB 0x12 -> 0xFFFFFFAA; LBU 0x12 -> 0x000000AA.
- Word 4 = 0x8001FFFF. LH 0x12 -> 0xFFFF8001; LHU 0x10 -> 0x0000FFFF.
- LW 0x13 and SH 0x11 -> resp_exc=1, mem_we never asserted. SW 0x3000 -> resp_exc=1.
- resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout.
- reset pulled low mid-WRITE of SB -> no mem_we, outputs at reset values immediately, next LW returns the old word.
